packet_action_egress: RTL and testbench
=======================================

// Module: packet_action_egress
// PURPOSE
//  Drain-side consumer of the packet FIFO. Takes the byte stream, the pkt_sop pulse and the per-packet action word.
//  Decodes the action: drop, forward, forward with dest-MAC rewrite, or punt.
//  Emits surviving packets on one registered byte stream tagged with an egress port, and keeps fwd/drop stats.
// PARAMETERS
//  ACTION_W   64  action word width (>=64)
//  NUM_PORTS  4   number of egress ports; valid port indices 0..NUM_PORTS-1
//  PORT_W     $clog2(NUM_PORTS)  out_port width
//  PUNT_PORT  NUM_PORTS-1  egress port used by opcode PUNT
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         synchronous active-low reset
//  in_valid   in   1         input byte valid
//  in_data    in   8         input byte
//  in_last    in   1         last byte of packet
//  in_ready   out  1         input byte accepted when in_valid&&in_ready
//  in_sop     in   1         1-cycle pulse: in_action valid; precedes the packet's first byte
//  in_action  in   ACTION_W  [1:0] op (0 DROP, 1 FWD, 2 FWD_RW, 3 PUNT); [7:4] port; [63:16] new dest MAC, byte0=[63:56]
//  out_valid  out  1         output byte valid
//  out_data   out  8         output byte
//  out_last   out  1         last byte of output packet
//  out_sop    out  1         high with the first byte of each output packet
//  out_port   out  PORT_W    egress port; constant for a whole packet
//  out_ready  in   1         downstream accept
//  fwd_cnt    out  32        packets forwarded (counted on last byte out), saturating
//  drop_cnt   out  32        packets dropped (counted on in_sop), saturating
//  proto_err  out  1         sticky: in_sop seen while not IDLE
// BEHAVIOUR
//  Reset: state IDLE; out_valid/out_last/out_sop=0; out_data=0; out_port=0; counters=0; proto_err=0; byte_idx=0.
//  FSM:
//   IDLE: in_ready=0. On in_sop, latch action; byte_idx<=0. Next state:
//    - DROP if op==DROP, or op in {FWD,FWD_RW} with port>=NUM_PORTS; drop_cnt+1.
//    - else XFER; latched port = PUNT_PORT for PUNT, else action[7:4].
//   XFER: in_ready = !out_valid || out_ready (1-entry output register).
//    Accepted byte loads out_* at the same edge, giving 1-cycle latency.
//    Byte_idx-th byte replaced by MAC byte byte_idx when op==FWD_RW and byte_idx<6.
//    byte_idx increments per accepted byte, saturating at 6.
//    Accepted in_last -> IDLE.
//   DROP: in_ready=1; bytes discarded, out_* untouched; accepted in_last -> IDLE.
//  in_sop may arrive the cycle after in_last is accepted; it must be taken without a bubble.
//  in_sop outside IDLE: proto_err<=1, pulse ignored, current packet unaffected.
//  Output register: out_valid holds with out_* stable while !out_ready.
//   Cleared when out_ready and no new byte loads.
//   Back-to-back bytes sustain 1 byte/cycle with out_ready=1.
//  out_sop=1 only on byte_idx==0 byte; out_port loaded with every byte.
//  fwd_cnt+1 when out_valid&&out_ready&&out_last.
//  Both counters saturate at 32'hFFFF_FFFF.
//  Packets shorter than 6 bytes under FWD_RW rewrite only the bytes present.
//  1-byte packet: out_sop and out_last in the same beat.
//  Simultaneous drop_cnt/fwd_cnt events both apply.
//  in_valid in IDLE is ignored (in_ready=0).
//  Reset mid-packet: all state cleared; the remainder of an in-flight packet is treated as stray bytes until next in_sop.
// TESTING
//  1. sop op=FWD port=2, 4 bytes 11,22,33,44, out_ready=1
//     -> out 11..44 port=2, sop on 11, last on 44, 1-cycle latency; fwd_cnt=1.
//  2. FWD_RW MAC=AA..FF, 8-byte packet -> bytes0-5=AA,BB,CC,DD,EE,FF, bytes6-7 unchanged;
//     3-byte packet -> AA,BB,CC.
//  3. DROP, then FWD port=9 (NUM_PORTS=4) -> no out_valid, in_ready=1 throughout; drop_cnt=2, fwd_cnt=0.
//  4. PUNT, out_ready toggling 1,0,0,1 -> out_port=3, data held stable while stalled, no loss/dup, in_ready low while stalled.
//  5. sop again one cycle after in_last -> second packet back-to-back; mid-packet sop -> proto_err=1, packet intact.
//  6. rst_n low mid-XFER -> all outputs zero next cycle; new sop+packet forwards correctly.

Source files
------------

// File: rtl/packet_action_egress.sv
// Egress stage of the packet FIFO: decodes the per-packet action and
// forwards, rewrites, punts or drops the byte stream behind it.
module packet_action_egress #(
   parameter int ACTION_W  = 64,
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = $clog2(NUM_PORTS),
   parameter int PUNT_PORT = NUM_PORTS - 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   input  logic                in_last,
   output logic                in_ready,
   input  logic                in_sop,
   input  logic [ACTION_W-1:0] in_action,
   output logic                out_valid,
   output logic [7:0]          out_data,
   output logic                out_last,
   output logic                out_sop,
   output logic [PORT_W-1:0]   out_port,
   input  logic                out_ready,
   output logic [31:0]         fwd_cnt,
   output logic [31:0]         drop_cnt,
   output logic                proto_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [1:0] OP_DROP = 2'd0;
   localparam logic [1:0] OP_FWD  = 2'd1;
   localparam logic [1:0] OP_RW   = 2'd2;
   localparam logic [1:0] OP_PUNT = 2'd3;

   localparam logic [4:0]        NP5    = 5'(NUM_PORTS);
   localparam logic [PORT_W-1:0] PUNT_P = PORT_W'(PUNT_PORT);

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          op_q;
   logic [PORT_W-1:0]   port_q;
   logic [47:0]         mac_q;
   logic [2:0]          byte_idx;

   logic [1:0]          sop_op;
   logic [3:0]          sop_port;
   logic                sop_drop;
   logic [PORT_W-1:0]   sop_port_sel;
   logic                acc;
   logic [47:0]         mac_sh;
   logic [7:0]          byte_out;
   logic                unused_bits;

   assign sop_op   = in_action[1:0];
   assign sop_port = in_action[7:4];
   assign sop_drop = (sop_op == OP_DROP) ||
                     (((sop_op == OP_FWD) || (sop_op == OP_RW)) &&
                      ({1'b0, sop_port} >= NP5));
   assign sop_port_sel = (sop_op == OP_PUNT) ? PUNT_P
                                             : sop_port[PORT_W-1:0];
   assign unused_bits = ^{in_action[15:8], in_action[3:2]};

   generate
      if (ACTION_W > 64) begin : g_wide
         logic unused_hi;
         assign unused_hi = ^in_action[ACTION_W-1:64];
      end
   endgenerate

   assign acc = in_valid && in_ready;

   // MAC byte 0 sits in the top byte, so shift it up into [47:40]
   assign mac_sh   = mac_q << {byte_idx, 3'b000};
   assign byte_out = ((op_q == OP_RW) && (byte_idx < 3'd6)) ? mac_sh[47:40]
                                                          : in_data;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_sop) state_nxt = sop_drop ? DROP : XFER;
         XFER: if (acc && in_last) state_nxt = IDLE;
         DROP: if (acc && in_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         XFER: in_ready = !out_valid || out_ready;
         DROP: in_ready = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_DROP;
         port_q    <= '0;
         mac_q     <= '0;
         byte_idx  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sop   <= 1'b0;
         out_port  <= '0;
         fwd_cnt   <= '0;
         drop_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_sop && (state == IDLE)) begin
            op_q     <= sop_op;
            port_q   <= sop_port_sel;
            mac_q    <= in_action[63:16];
            byte_idx <= '0;
            if (sop_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
         end
         if (in_sop && (state != IDLE)) proto_err <= 1'b1;
         if ((state == XFER) && acc) begin
            out_valid <= 1'b1;
            out_data  <= byte_out;
            out_last  <= in_last;
            out_sop   <= (byte_idx == 3'd0);
            out_port  <= port_q;
            if (byte_idx != 3'd6) byte_idx <= byte_idx + 3'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready && out_last && (fwd_cnt != '1))
            fwd_cnt <= fwd_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_packet_action_egress.sv
// Randomized scoreboard bench for packet_action_egress.
// A packet-level model queues expected beats; a monitor checks them.
module tb_packet_action_egress;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [7:0] d;
      logic       last;
      logic       sop;
      logic [1:0] port;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        in_sop = 1'b0;
   logic [63:0] in_action = '0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_sop;
   logic [1:0]  out_port;
   logic        out_ready = 1'b1;
   logic [31:0] fwd_cnt;
   logic [31:0] drop_cnt;
   logic        proto_err;

   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   int   exp_fwd = 0;
   int   exp_drop = 0;
   bit   exp_proto = 0;
   bit   lat_chk = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   packet_action_egress #(
      .ACTION_W(64), .NUM_PORTS(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .in_sop(in_sop), .in_action(in_action),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_sop(out_sop), .out_port(out_port), .out_ready(out_ready),
      .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt), .proto_err(proto_err)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // out_ready: 0 always high, 1 random, 2 held low, 3 pattern 1,0,0,1
   initial begin
      int k = 0;
      logic [3:0] pat = 4'b1001;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            3: out_ready = pat[k % 4];
            default: out_ready = 1'b0;
         endcase
         k++;
      end
   end

   logic        hv = 1'b0;
   logic [12:0] held = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hv = 1'b0;
      end else begin
         if (hv)
            chk("stall_stable",
                {out_valid, out_data, out_last, out_sop, out_port}, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("out_beat", {out_data, out_last, out_sop, out_port},
                   {e.d, e.last, e.sop, e.port});
            end
         end
         hv   = out_valid && !out_ready;
         held = {out_valid, out_data, out_last, out_sop, out_port};
      end
   end

   function automatic bq_t rnd_bytes(input int len);
      bq_t q;
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic send_pkt(input logic [1:0] op, input logic [3:0] port,
                           input logic [47:0] mac, input bq_t data,
                           input int midsop, input bit gaps);
      int         len;
      bit         drop;
      bit         acc;
      int         n;
      exp_t       e;
      logic [7:0] ed[$];
      logic [7:0] d;
      len  = data.size();
      drop = (op == 2'd0) || ((op != 2'd3) && (port >= 4'd4));
      for (int i = 0; i < len; i++) begin
         d = data[i];
         if ((op == 2'd2) && (i < 6)) d = mac[8*(5-i) +: 8];
         ed.push_back(d);
      end
      if (drop) begin
         exp_drop++;
      end else begin
         exp_fwd++;
         for (int i = 0; i < len; i++) begin
            e.d    = ed[i];
            e.last = (i == len - 1);
            e.sop  = (i == 0);
            e.port = (op == 2'd3) ? 2'd3 : port[1:0];
            exp_q.push_back(e);
         end
      end
      in_action = {mac, 8'($urandom), port, 2'($urandom), op};
      in_sop = 1'b1;
      tick();
      in_sop = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_data  = data[i];
         in_last  = (i == len - 1);
         if (i == midsop) begin
            in_sop    = 1'b1;
            in_action = {$urandom, $urandom};
            exp_proto = 1'b1;
         end
         acc = 1'b0;
         n   = 0;
         while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (drop)
               chk("drop_in_ready", in_ready, 1'b1);
            else if (out_valid && !out_ready)
               chk("stall_in_ready", in_ready, 1'b0);
            if (lat_chk && (i > 0))
               chk("latency", {out_valid, out_data}, {1'b1, ed[i-1]});
            @(posedge clk);
            #1;
            in_sop = 1'b0;
            n++;
            if (!acc && (n > 100)) begin
               chk("in_accept_timeout", acc, 1'b1);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (lat_chk) begin
         @(negedge clk);
         chk("latency_last", {out_valid, out_last, out_data},
             {1'b1, 1'b1, ed[len-1]});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (((exp_q.size() != 0) || out_valid) && (n < 500)) begin
         tick();
         n++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   task automatic chk_stats(input string tag);
      chk({tag, "_fwd_cnt"}, fwd_cnt, 32'(exp_fwd));
      chk({tag, "_drop_cnt"}, drop_cnt, 32'(exp_drop));
      chk({tag, "_proto_err"}, proto_err, exp_proto);
   endtask

   initial begin
      bq_t q;
      tick();
      tick();
      @(negedge clk);
      chk("rst_out", {out_valid, out_last, out_sop, out_data, out_port}, 0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk_stats("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      rdy_mode = 0;
      lat_chk  = 1;
      q = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_pkt(2'd1, 4'd2, 48'h0, q, -1, 0);
      lat_chk = 0;
      drain();
      chk_stats("fwd4");

      send_pkt(2'd2, 4'd1, 48'hAABBCCDDEEFF, rnd_bytes(8), -1, 0);
      send_pkt(2'd2, 4'd0, 48'hAABBCCDDEEFF, rnd_bytes(3), -1, 0);
      drain();

      send_pkt(2'd0, 4'd1, 48'h0, rnd_bytes(5), -1, 0);
      send_pkt(2'd1, 4'd9, 48'h0, rnd_bytes(4), -1, 0);
      drain();
      chk_stats("drops");

      rdy_mode = 3;
      send_pkt(2'd3, 4'd0, 48'h0, rnd_bytes(10), -1, 0);
      drain();

      rdy_mode = 0;
      send_pkt(2'd1, 4'd1, 48'h0, rnd_bytes(3), -1, 0);
      send_pkt(2'd1, 4'd3, 48'h0, rnd_bytes(1), -1, 0);
      send_pkt(2'd1, 4'd2, 48'h0, rnd_bytes(6), 2, 0);
      drain();
      chk_stats("b2b");

      for (int p = 0; p < 40; p++) begin
         rdy_mode = ($urandom_range(0, 2) == 0) ? 0
                  : (($urandom_range(0, 1) == 0) ? 1 : 3);
         send_pkt(2'($urandom), 4'($urandom_range(0, 5)),
                  {16'($urandom), $urandom},
                  rnd_bytes($urandom_range(1, 10)), -1,
                  1'($urandom_range(0, 1)));
      end
      rdy_mode = 0;
      drain();
      chk_stats("random");

      rdy_mode = 2;
      tick();
      in_action = {48'h010203040506, 8'h00, 4'd1, 2'd0, 2'd1};
      in_sop = 1'b1;
      tick();
      in_sop   = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
      tick();
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      exp_fwd   = 0;
      exp_drop  = 0;
      exp_proto = 0;
      chk("midrst_out",
          {out_valid, out_last, out_sop, out_data, out_port}, 0);
      chk_stats("midrst");
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      rdy_mode = 0;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(i);
         in_last = (i == 2);
         @(negedge clk);
         chk("stray_in_ready", in_ready, 1'b0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      send_pkt(2'd1, 4'd1, 48'h0, rnd_bytes(5), -1, 0);
      drain();
      chk_stats("postrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
